// File: rtl/dqn_pkg.sv
// Shared types and helpers for the output-layer bias scheduler: FSM states,
// register-file control codes, constant clog2 and signed saturation.
package dqn_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, SCALE, APPLY, DONE} state_t;

  localparam logic [3:0] CTRL_UPDATE = 4'b0001;
  localparam logic [3:0] CTRL_IDLE   = 4'b0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Clamp to the signed range of a dw-bit word; caller keeps the low dw bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/bias2_lane_acc.sv
// One bias lane: sums signed deltas over a batch, scales by the learning-rate
// shift and narrows to DW bits (saturating when BIAS2_SAT_EN is defined).
module bias2_lane_acc
  import dqn_pkg::*;
#(
  parameter int DW       = 16,
  parameter int BATCH    = 8,
  parameter int LR_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add,
  input  logic                 load,
  input  logic signed [DW-1:0] d_in,
  output logic signed [DW-1:0] deltab2
);

  localparam int ACC_W = DW + clog2(BATCH);

  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] scaled;

  function automatic logic signed [DW-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef BIAS2_SAT_EN
    logic signed [63:0] w;
    w = sat_narrow(64'(v), DW);
    return $signed(w[DW-1:0]);
`else
    return $signed(v[DW-1:0]);
`endif
  endfunction

  assign scaled = acc_p0 >>> LR_SHIFT;

  // Stage p0: batch sum; stage p1: scaled, narrowed value held for the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0  <= '0;
      deltab2 <= '0;
    end else begin
      if (clr)      acc_p0 <= '0;
      else if (add) acc_p0 <= acc_p0 + ACC_W'(d_in);
      if (load)     deltab2 <= narrow(scaled);
    end
  end

endmodule

// File: rtl/bias2_update_sched.sv
// Mini-batch scheduler for the 5-lane bias2 register file: accumulate, scale,
// issue one update, pulse done. Build option: BIAS2_SAT_EN (saturating narrow).
module bias2_update_sched
  import dqn_pkg::*;
#(
  parameter int BATCH    = 8,
  parameter int LR_SHIFT = 3,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic signed [DW-1:0] d_in_1,
  input  logic signed [DW-1:0] d_in_2,
  input  logic signed [DW-1:0] d_in_3,
  input  logic signed [DW-1:0] d_in_4,
  input  logic signed [DW-1:0] d_in_5,
  output logic [3:0]           ctrl,
  output logic [3:0]           step,
  output logic signed [DW-1:0] deltab2_1,
  output logic signed [DW-1:0] deltab2_2,
  output logic signed [DW-1:0] deltab2_3,
  output logic signed [DW-1:0] deltab2_4,
  output logic signed [DW-1:0] deltab2_5,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = clog2(BATCH) + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               xfer;
  logic               last;
  logic               clr;
  logic signed [DW-1:0] din  [5];
  logic signed [DW-1:0] dout [5];

  assign din[0] = d_in_1;
  assign din[1] = d_in_2;
  assign din[2] = d_in_3;
  assign din[3] = d_in_4;
  assign din[4] = d_in_5;

  assign deltab2_1 = dout[0];
  assign deltab2_2 = dout[1];
  assign deltab2_3 = dout[2];
  assign deltab2_4 = dout[3];
  assign deltab2_5 = dout[4];

  assign d_ready = (state == ACCUM);
  assign xfer    = d_valid & d_ready;
  assign last    = (count == CNT_W'(BATCH - 1));
  assign clr     = (state == IDLE) & start;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign ctrl    = (state == APPLY) ? CTRL_UPDATE : CTRL_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (xfer && last) state_nxt = SCALE;
      SCALE:   state_nxt = APPLY;
      APPLY:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step advances as the scaled deltas are loaded so both are valid during APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      step  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (clr)       count <= '0;
      else if (xfer) count <= count + CNT_W'(1);
      if (state == SCALE) step <= (step == 4'd15) ? 4'd1 : step + 4'd1;
    end
  end

  for (genvar k = 0; k < 5; k++) begin : g_lane
    bias2_lane_acc #(
      .DW      (DW),
      .BATCH   (BATCH),
      .LR_SHIFT(LR_SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .add    (xfer),
      .load   (state == SCALE),
      .d_in   (din[k]),
      .deltab2(dout[k])
    );
  end

endmodule

// File: tb/tb_bias2_update_sched.sv
// Randomised bench for bias2_update_sched: two instances (LR_SHIFT 3 and 0) share
// stimulus and are compared every cycle against a batch-level reference model.
module tb_bias2_update_sched;

  localparam int BATCH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        d_valid = 1'b0;
  logic [15:0] din [5];
  logic        rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
  logic [3:0]  ctrl_a, step_a, ctrl_b, step_b;
  logic [15:0] db_a [5];
  logic [15:0] db_b [5];

  always #5 clk = ~clk;

  bias2_update_sched #(.BATCH(BATCH), .LR_SHIFT(3), .DW(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .d_valid(d_valid), .d_ready(rdy_a),
    .d_in_1(din[0]), .d_in_2(din[1]), .d_in_3(din[2]), .d_in_4(din[3]), .d_in_5(din[4]),
    .ctrl(ctrl_a), .step(step_a),
    .deltab2_1(db_a[0]), .deltab2_2(db_a[1]), .deltab2_3(db_a[2]),
    .deltab2_4(db_a[3]), .deltab2_5(db_a[4]),
    .busy(busy_a), .done(done_a)
  );

  bias2_update_sched #(.BATCH(BATCH), .LR_SHIFT(0), .DW(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .d_valid(d_valid), .d_ready(rdy_b),
    .d_in_1(din[0]), .d_in_2(din[1]), .d_in_3(din[2]), .d_in_4(din[3]), .d_in_5(din[4]),
    .ctrl(ctrl_b), .step(step_b),
    .deltab2_1(db_b[0]), .deltab2_2(db_b[1]), .deltab2_3(db_b[2]),
    .deltab2_4(db_b[3]), .deltab2_5(db_b[4]),
    .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int ctrl_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: phase 0 idle, 1 collecting, 2 scaling, 3 update, 4 finished.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_step  = 0;
  int m_sum  [5];
  int m_db_a [5];
  int m_db_b [5];

  function automatic int narrow16(input int v);
    int r;
    r = v;
`ifdef BIAS2_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r & 32'h0000FFFF;
  endfunction

  always @(posedge clk) begin
    int ph, cnt, stp;
    int s [5];
    int da [5];
    int dbb [5];
    ph = m_phase; cnt = m_cnt; stp = m_step;
    s = m_sum; da = m_db_a; dbb = m_db_b;
    if (rst) begin
      ph = 0; cnt = 0; stp = 0;
      for (int k = 0; k < 5; k++) begin s[k] = 0; da[k] = 0; dbb[k] = 0; end
    end else begin
      case (ph)
        0: if (start) begin
             ph = 1; cnt = 0;
             for (int k = 0; k < 5; k++) s[k] = 0;
           end
        1: if (d_valid) begin
             for (int k = 0; k < 5; k++) s[k] = s[k] + int'($signed(din[k]));
             cnt = cnt + 1;
             if (cnt == BATCH) ph = 2;
           end
        2: begin
             for (int k = 0; k < 5; k++) begin
               da[k]  = narrow16(s[k] >>> 3);
               dbb[k] = narrow16(s[k]);
             end
             stp = (stp % 15) + 1;
             ph = 3;
           end
        3: ph = 4;
        default: ph = 0;
      endcase
    end
    m_phase <= ph; m_cnt <= cnt; m_step <= stp;
    m_sum <= s; m_db_a <= da; m_db_b <= dbb;
  end

  always @(negedge clk) begin
    if (ctrl_a == 4'b0001) ctrl_total <= ctrl_total + 1;
    if (chk_en) begin
      chk("d_ready_a", int'(rdy_a),  int'(m_phase == 1));
      chk("d_ready_b", int'(rdy_b),  int'(m_phase == 1));
      chk("busy_a",    int'(busy_a), int'(m_phase != 0));
      chk("done_a",    int'(done_a), int'(m_phase == 4));
      chk("done_b",    int'(done_b), int'(m_phase == 4));
      chk("ctrl_a",    int'(ctrl_a), (m_phase == 3) ? 1 : 0);
      chk("ctrl_b",    int'(ctrl_b), (m_phase == 3) ? 1 : 0);
      chk("step_a",    int'(step_a), m_step);
      chk("step_b",    int'(step_b), m_step);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("deltab2_a[%0d]", k + 1), int'(db_a[k]), m_db_a[k]);
        chk($sformatf("deltab2_b[%0d]", k + 1), int'(db_b[k]), m_db_b[k]);
      end
    end
  end

  task automatic set_data(input int kind);
    for (int k = 0; k < 5; k++) begin
      case (kind)
        1: din[k] = 16'h0010;
        2: din[k] = (k != 0) ? 16'h0000 : ((m_cnt % 2 == 0) ? 16'h0005 : 16'hFFF9);
        3: din[k] = 16'h7FFF;
        default: din[k] = 16'($urandom);
      endcase
    end
  endtask

  // Runs one batch; returns at #1 after the edge that enters the done cycle.
  task automatic run_batch(input int kind, input bit toggle, input bit poke_start, output int ctrl_seen);
    int cyc;
    int base;
    cyc = 0;
    base = ctrl_total;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!done_a && cyc < 100) begin
      d_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      set_data(kind);
      start = poke_start && (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    d_valid = 1'b0;
    start   = 1'b0;
    if (cyc >= 100) chk("batch_timeout", 0, 1);
    ctrl_seen = ctrl_total - base;
  endtask

  initial begin
    int cs;
    int cyc;
    for (int k = 0; k < 5; k++) din[k] = 16'h0000;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", int'(ctrl_a), 0);
    chk("rst_step", int'(step_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_ready", int'(rdy_a), 0);
    chk("rst_db1", int'(db_a[0]), 0);
    rst = 1'b0;

    // Constant deltas of 16 per lane.
    run_batch(1, 1'b0, 1'b0, cs);
    chk("t1_done", int'(done_a), 1);
    chk("t1_ctrl_pulses", cs, 1);
    chk("t1_step", int'(step_a), 1);
    for (int k = 0; k < 5; k++) chk("t1_db_a", int'(db_a[k]), 16'h0010);
    chk("t1_db_b", int'(db_b[0]), 16'h0080);

    // +5/-7 alternating on lane 1: floor(-8/8) = -1.
    run_batch(2, 1'b0, 1'b0, cs);
    chk("t2_db_a1", int'(db_a[0]), 16'hFFFF);
    chk("t2_db_b1", int'(db_b[0]), 16'hFFF8);
    chk("t2_db_a2", int'(db_a[1]), 0);

    // Full-scale positive deltas.
    run_batch(3, 1'b0, 1'b0, cs);
    chk("t3_db_a", int'(db_a[2]), 16'h7FFF);
`ifdef BIAS2_SAT_EN
    chk("t3_db_b", int'(db_b[2]), 16'h7FFF);
`else
    chk("t3_db_b", int'(db_b[2]), 16'hFFF8);
`endif

    // Gapped valid with a stray start during collection.
    run_batch(0, 1'b1, 1'b1, cs);
    chk("t4_ctrl_pulses", cs, 1);
    chk("t4_step", int'(step_a), 4);

    // Reset after 5 accepted vectors.
    cs = ctrl_total;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (m_cnt < 5 && cyc < 50) begin
      d_valid = 1'b1;
      set_data(0);
      @(posedge clk); #1;
      cyc++;
    end
    d_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_no_ctrl", ctrl_total - cs, 0);
    chk("t5_step", int'(step_a), 0);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_db1", int'(db_a[0]), 0);
    chk("t5_db5", int'(db_b[4]), 0);
    run_batch(1, 1'b0, 1'b0, cs);
    chk("t5_fresh_db", int'(db_a[3]), 16'h0010);
    chk("t5_fresh_step", int'(step_a), 1);

    // Sixteen back-to-back batches from reset: steps 1..15 then 1.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_batch(0, 1'($urandom_range(0, 1)), 1'b0, cs);
      chk($sformatf("t6_step[%0d]", i), int'(step_a), (i % 15) + 1);
      chk("t6_ctrl_pulses", cs, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
